// File: rtl/rowunit_layer_sched_pkg.sv
// Shared definitions for the row-unit layer read scheduler:
// FSM state encoding, default pipeline/gap constants, iteration width.
package rowunit_layer_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam int PIPESTAGES_DEF = 11;
  localparam int ITERBITS_DEF   = 4;

  // Idle cycles after a layer so the last LLR write-back retires first.
  function automatic int layer_gap(input int pipestages);
    return pipestages + 2;
  endfunction

  localparam int LAYERGAP_DEF = layer_gap(PIPESTAGES_DEF);

  // Counter width for a modulus, never below one bit.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with synchronous clear, count enable and a
// terminal-count flag; wraps to zero after MODULUS-1.
module mod_counter #(
  parameter int MODULUS = 2,
  parameter int WIDTH   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign wrap_o  = (count_q == LAST);
  assign count_o = count_q;

  // Next count: clear wins over enable; wrap at the terminal value.
  always_comb begin
    // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = wrap_o ? '0 : count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rowunit_layer_sched.sv
// Row-unit layer read scheduler: issues ADDRDEPTH reads per layer for every
// layer of every iteration, with LAYERGAP idle cycles after each layer, and
// stops at the iteration limit or on early_stop at an iteration boundary.
module rowunit_layer_sched
  import rowunit_layer_sched_pkg::*;
#(
  parameter int LAYERS     = 2,
  parameter int ADDRWIDTH  = 5,
  parameter int ADDRDEPTH  = 20,
  parameter int PIPESTAGES = PIPESTAGES_DEF,
  parameter int LAYERGAP   = layer_gap(PIPESTAGES),
  parameter int ITERBITS   = ITERBITS_DEF,
  parameter int LAYERBITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ITERBITS-1:0]  max_iter,
  input  logic                 early_stop,
  output logic [LAYERBITS-1:0] rdlayer,
  output logic [ADDRWIDTH-1:0] rdaddress,
  output logic                 rden_LLR,
  output logic                 rden_E,
  output logic [ITERBITS-1:0]  iter_count,
  output logic                 busy,
  output logic                 done
);

  localparam int GAPW = cnt_width(LAYERGAP);

  sched_state_e         state_q;
  logic [ITERBITS-1:0]  iter_q;
  logic [ITERBITS-1:0]  limit_q;
  logic [ADDRWIDTH-1:0] rdaddress_q;
  logic                 rden_llr_q;
  logic                 rden_e_q;
  logic                 busy_q;
  logic                 done_q;

  logic [ADDRWIDTH-1:0] addr_cnt;
  logic [LAYERBITS-1:0] layer_cnt;
  logic [GAPW-1:0]      unused_gap_cnt;
  logic                 addr_last;
  logic                 layer_last;
  logic                 gap_last;

  logic accept;
  logic gap_en;
  logic iter_last;

  assign accept    = (state_q == ST_IDLE) && start;
  assign gap_en    = (state_q == ST_GAP);
  assign iter_last = (iter_q == (limit_q - ITERBITS'(1)));

  mod_counter #(.MODULUS(ADDRDEPTH), .WIDTH(ADDRWIDTH)) u_addr_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (accept),
    .en_i    (state_q == ST_ISSUE),
    .count_o (addr_cnt),
    .wrap_o  (addr_last)
  );

  // Advances on the final gap cycle; wraps to layer 0 at an iteration boundary.
  mod_counter #(.MODULUS(LAYERS), .WIDTH(LAYERBITS)) u_layer_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (accept),
    .en_i    (gap_en && gap_last),
    .count_o (layer_cnt),
    .wrap_o  (layer_last)
  );

  mod_counter #(.MODULUS(LAYERGAP), .WIDTH(GAPW)) u_gap_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (accept),
    .en_i    (gap_en),
    .count_o (unused_gap_cnt),
    .wrap_o  (gap_last)
  );

  // Sequencer FSM; every output is registered here alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      iter_q      <= '0;
      limit_q     <= '0;
      rdaddress_q <= '0;
      rden_llr_q  <= 1'b0;
      rden_e_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_ISSUE;
            limit_q     <= (max_iter == '0) ? ITERBITS'(1) : max_iter;
            iter_q      <= '0;
            rdaddress_q <= '0;
            rden_llr_q  <= 1'b1;
            rden_e_q    <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (addr_last) begin
            // Address output holds its last value through the gap.
            state_q    <= ST_GAP;
            rden_llr_q <= 1'b0;
            rden_e_q   <= 1'b0;
          end else begin
            rdaddress_q <= addr_cnt + ADDRWIDTH'(1);
          end
        end
        ST_GAP: begin
          if (gap_last) begin
            if (!layer_last) begin
              state_q     <= ST_ISSUE;
              rdaddress_q <= '0;
              rden_llr_q  <= 1'b1;
              rden_e_q    <= (iter_q != '0);
            end else if (early_stop || iter_last) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ST_ISSUE;
              iter_q      <= iter_q + ITERBITS'(1);
              rdaddress_q <= '0;
              rden_llr_q  <= 1'b1;
              rden_e_q    <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdlayer    = layer_cnt;
  assign rdaddress  = rdaddress_q;
  assign rden_LLR   = rden_llr_q;
  assign rden_E     = rden_e_q;
  assign iter_count = iter_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/rowunit_layer_sched.md
# rowunit_layer_sched

Sequencing controller for the SISO row unit: on a start request it issues the per-layer read stream (`rdlayer`, `rdaddress`, `rden_LLR`, `rden_E`) for every layer of every decoding iteration. Between layers it inserts a fixed idle gap so that LLR write-backs from the row-unit pipeline retire before the next layer reads them. It counts iterations, honours an early-stop flag at iteration boundaries, and reports completion with busy/done. It sits between the decoder top-level control and the row-unit `*_regin` read inputs.

## Interface
Parameters:
- `LAYERS`, 2, number of layers per iteration.
- `ADDRWIDTH`, 5, width of the per-layer address.
- `ADDRDEPTH`, 20, number of addresses issued per layer (0..ADDRDEPTH-1).
- `PIPESTAGES`, 11, row-unit pipeline depth.
- `LAYERGAP`, PIPESTAGES+2 (13), number of idle cycles after each layer. Must be at least 1.
- `ITERBITS`, 4, width of the iteration count.
- `LAYERBITS`, 1, width of the layer index. Must satisfy 2^LAYERBITS ≥ LAYERS.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  decode request. Sampled only in IDLE.
- `max_iter`  in  ITERBITS  iteration limit, latched on an accepted start. A value of 0 is treated as 1.
- `early_stop`  in  1  syndrome-satisfied flag, sampled at iteration boundaries.
- `rdlayer`  out  LAYERBITS  layer index of the current read.
- `rdaddress`  out  ADDRWIDTH  read address.
- `rden_LLR`  out  1  LLR read enable; high on every issue cycle.
- `rden_E`  out  1  E-memory read enable; equals `rden_LLR` except during iteration 0, where it is held low.
- `iter_count`  out  ITERBITS  index of the current iteration, starting at 0.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle completion pulse.

## Operation
FSM states: IDLE, ISSUE, GAP, DONE.
- **IDLE**
  - `start` = 1 latches `max_iter`, clears the counters and moves to ISSUE.
  - `start` = 0 stays in IDLE.
- **ISSUE**
  - Drives `rden_LLR` = 1, `rdlayer` = current layer, `rdaddress` = current address.
  - The address increments by 1 each cycle.
  - When the address reaches ADDRDEPTH-1, the address wraps to 0 and the FSM moves to GAP.
- **GAP**
  - All enables are 0. `rdaddress` and `rdlayer` hold their last issued values.
  - The gap counter runs for LAYERGAP cycles. On its final cycle:
    - Not the last layer: layer increments, return to ISSUE.
    - Last layer and (`early_stop` = 1 or `iter_count` = limit-1): go to DONE.
    - Otherwise: layer wraps to 0, `iter_count` increments, return to ISSUE.
- **DONE**
  - `done` = 1 and `busy` = 0 for exactly one cycle, then return to IDLE.
  - `iter_count` holds its final value until the next accepted start.

Width and arithmetic rules:
- All counters are unsigned. The address counter saturates its compare at ADDRDEPTH-1 and never exceeds it.
- `early_stop` is ignored except on the final GAP cycle of the last layer.
- `start` is ignored while `busy` = 1. There is no restart mid-decode.

Reset (asserted at any time, including mid-decode):
- FSM returns to IDLE immediately.
- All outputs and counters go to 0: `rdlayer`, `rdaddress`, `rden_LLR`, `rden_E`, `iter_count`, `busy`, `done`.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- Start accepted on edge k → first issue (`rden_LLR` = 1, layer 0, address 0) visible in cycle k+1, with `busy` = 1.
- Each layer takes ADDRDEPTH issue cycles followed by LAYERGAP gap cycles.
- One iteration is LAYERS·(ADDRDEPTH+LAYERGAP) cycles; with the defaults this is 66.
- `done` is visible at cycle k+1+N·LAYERS·(ADDRDEPTH+LAYERGAP), where N is the number of iterations executed. With defaults and N = 2 this is k+133.
- The default LAYERGAP guarantees that the last write-back of a layer (12 cycles after its read request) completes before the next layer's first read.

## Structure
- The shared decoder package holds:
  - the FSM state encoding,
  - the LAYERGAP default derived from PIPESTAGES,
  - the ITERBITS constant.
- A single sub-module, `mod_counter` (parameterised modulus and width, with enable and wrap flag), is instantiated three times: for the address, layer and gap counters.
- The iteration counter stays inline because of its latched limit.

## Test plan
- Reset mid-ISSUE, released after 3 cycles → all outputs 0 and FSM in IDLE; next start → first read at layer 0, address 0.
- `max_iter` = 2, `early_stop` = 0, default parameters → exactly 80 `rden_LLR` cycles, `rden_E` high only for the last 40 of them, `done` at start+133, `iter_count` = 1.
- `max_iter` = 5, `early_stop` raised during iteration 0 and held → `done` at start+67 with `iter_count` = 0 (iteration 0 only), since the flag is sampled on the final gap cycle of the last layer; a pulse outside that cycle has no effect.
- `max_iter` = 0 → behaves as 1 iteration; `done` at start+67.
- `start` held high throughout the decode → no re-entry while busy; after the DONE cycle a new decode is accepted from IDLE.
- Address sequence check: in every layer the addresses run 0..19 consecutively, followed by exactly 13 idle cycles; `rdlayer` toggles 0,1,0,1.
